dyn_addr_update_ctrl: RTL and testbench
=======================================

Name: dyn_addr_update_ctrl

Overview:
- Multi-device successor to the standby-controller address wiring.
- Collects SETDASA / RSTDAA / SETNEWDA / RSTACT events from the CCC decoder for NumDevs device identities (index 0 = main target, 1..NumDevs-1 = virtual targets).
- Buffers one pending address operation per device and commits them to the STBY_CR_*DEVICE_ADDR CSR hwif (we/next) through a round-robin arbiter, one per cycle.
- Defers commits on software-write collisions; reports address-change pulses, rejected and overrun events.

Parameters:
- NumDevs, 2, number of device identities (>=1).
- AddrWidth, 7, dynamic address width.
- RstActWidth, 8, RSTACT defining-byte width.
- DevIdxW, (NumDevs>1 ? $clog2(NumDevs) : 1), device index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- set_dasa_valid_i  in  1  SETDASA/SETAASA assignment strobe.
- set_dasa_addr_i  in  AddrWidth  assigned address.
- set_dasa_dev_i  in  DevIdxW  target device index.
- rstdaa_i  in  1  broadcast RSTDAA strobe (all devices).
- set_newda_i  in  1  SETNEWDA strobe.
- newda_i  in  AddrWidth  new address.
- newda_dev_i  in  DevIdxW  target device index.
- rst_action_valid_i  in  1  RSTACT strobe.
- rst_action_i  in  RstActWidth  RSTACT defining byte.
- rst_action_clr_i  in  1  reset action consumed.
- sw_busy_i  in  NumDevs  software CSR write to that device's address register this cycle.
- cur_valid_i  in  NumDevs  current DYNAMIC_ADDR_VALID from CSR.
- addr_we_o  out  NumDevs  CSR write-enable (DYNAMIC_ADDR and _VALID fields).
- addr_next_o  out  NumDevs*AddrWidth  CSR next address.
- addr_valid_next_o  out  NumDevs  CSR next valid.
- pending_o  out  NumDevs  operation buffered.
- dyn_addr_chg_o  out  NumDevs  one-cycle pulse after commit.
- newda_reject_o  out  1  one-cycle pulse when SETNEWDA is ignored.
- overrun_o  out  NumDevs  sticky: pending operation overwritten.
- overrun_clr_i  in  NumDevs  clear overrun bits.
- rst_action_o  out  RstActWidth  latched RSTACT byte.
- rst_action_we_o  out  1  CSR RST_ACTION write-enable pulse.

Behaviour:
- Reset (rst_i at clock edge): all pending slots empty, overrun_o=0, rst_action_o=0. All pulse outputs and addr_we_o/addr_next_o/addr_valid_next_o are 0. rst_i mid-operation discards pending slots without committing.
- Slot per device holds {addr, valid}. Event capture at edge N; pending_o visible in cycle N+1.
- Priority per device within one cycle: rstdaa_i > set_dasa > set_newda.
  - RSTDAA loads {0,0} into every slot.
  - SETDASA loads {addr,1} into slot set_dasa_dev_i.
  - SETNEWDA loads {newda_i,1} into slot newda_dev_i only if cur_valid_i=1 or that slot already pends valid=1. Otherwise it is ignored and newda_reject_o pulses at N+1.
- Device index >= NumDevs: event ignored, reject pulse for SETNEWDA; SETDASA is dropped silently.
- Overwrite: loading a slot that is pending and not committed this cycle sets overrun_o[d]. The latest value wins. overrun_clr_i[d] clears the bit; a simultaneous set wins over clear.
- Arbiter: combinational round-robin over pending & ~sw_busy_i. Pointer starts at 0 and advances to grant+1 (mod NumDevs) after each grant. Exactly one grant per cycle when eligible.
- Commit: in the granted cycle, addr_we_o[g]=1 with addr_next_o/addr_valid_next_o carrying the slot value (zero for non-granted lanes). The slot is cleared at the edge; dyn_addr_chg_o[g] pulses the following cycle.
- Minimum latency: event edge N -> addr_we_o in cycle N+1 -> dyn_addr_chg_o in cycle N+2.
- A new event for the slot being committed in the same cycle reloads the slot (load wins over clear), with no overrun flagged.
- sw_busy_i[d]=1 masks d only for that cycle; the commit retries afterwards.
- RSTACT:
  - rst_action_valid_i latches rst_action_i into rst_action_o; rst_action_we_o pulses the next cycle.
  - rst_action_clr_i zeros rst_action_o and pulses rst_action_we_o.
  - If valid and clear coincide, valid wins.

Decomposition:
- i3c_pkg: dev_addr_op_t struct {addr, valid}, RSTACT byte-width constant, DevIdxW helper function.
- Sub-module rr_arbiter (parametrised N; req/grant onehot, advance input) — reusable elsewhere in the design.

Test Plan:
- NumDevs=2: SETDASA addr 0x2A dev 0 at cycle 5 -> addr_we_o=2'b01, addr_next_o lane0=0x2A, valid 1 at cycle 6; dyn_addr_chg_o=2'b01 at cycle 7.
- Same cycle: SETDASA dev1 0x31 plus SETNEWDA dev0 0x40 (cur_valid_i=2'b01) -> commit dev0=0x40 at cycle N+1, dev1=0x31 at cycle N+2.
- RSTDAA coincident with SETDASA dev0 0x10 -> both lanes commit {0,0}; no 0x10 written.
- SETNEWDA dev1 with cur_valid_i[1]=0 and no pending -> newda_reject_o pulse, no addr_we_o.
- sw_busy_i[0] held 3 cycles with dev0 pending 0x22 -> no commit for 3 cycles, commit on 4th.
- Two SETDASA to dev0 (0x11 then 0x12) while sw_busy_i[0]=1 -> overrun_o[0]=1, 0x12 committed; overrun_clr_i[0] clears it.
- RSTACT 0x02 -> rst_action_o=0x02, rst_action_we_o pulse next cycle; rst_action_clr_i -> 0x00 with pulse.

Source files
------------

// File: rtl/i3c_pkg.sv
// Shared types and constants for the I3C target address-update logic.
package i3c_pkg;

    localparam int unsigned DaAddrWidth     = 7;
    localparam int unsigned RstActByteWidth = 8;

    typedef struct packed {
        logic [DaAddrWidth-1:0] addr;
        logic                   valid;
    } dev_addr_op_t;

    function automatic int unsigned dev_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner when advance_i is set.
module rr_arbiter #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned     idx;
        logic [IdxW-1:0] idx_w;
        logic            found;
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            idx_w = IdxW'(idx);
            if (!found && req_i[idx_w]) begin
                found          = 1'b1;
                grant_o[idx_w] = 1'b1;
                ptr_d          = (idx + 1 >= N) ? '0 : IdxW'(idx + 1);
            end
        end
        if (!advance_i) ptr_d = ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/dyn_addr_update_ctrl.sv
// Buffers per-device dynamic-address operations from the CCC decoder and commits them
// to the device address CSRs one per cycle through a round-robin arbiter.
module dyn_addr_update_ctrl
    import i3c_pkg::*;
#(
    parameter int unsigned NumDevs     = 2,
    parameter int unsigned AddrWidth   = DaAddrWidth,
    parameter int unsigned RstActWidth = RstActByteWidth,
    parameter int unsigned DevIdxW     = dev_idx_w(NumDevs)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         set_dasa_valid_i,
    input  logic [AddrWidth-1:0]         set_dasa_addr_i,
    input  logic [DevIdxW-1:0]           set_dasa_dev_i,
    input  logic                         rstdaa_i,
    input  logic                         set_newda_i,
    input  logic [AddrWidth-1:0]         newda_i,
    input  logic [DevIdxW-1:0]           newda_dev_i,
    input  logic                         rst_action_valid_i,
    input  logic [RstActWidth-1:0]       rst_action_i,
    input  logic                         rst_action_clr_i,
    input  logic [NumDevs-1:0]           sw_busy_i,
    input  logic [NumDevs-1:0]           cur_valid_i,
    output logic [NumDevs-1:0]           addr_we_o,
    output logic [NumDevs*AddrWidth-1:0] addr_next_o,
    output logic [NumDevs-1:0]           addr_valid_next_o,
    output logic [NumDevs-1:0]           pending_o,
    output logic [NumDevs-1:0]           dyn_addr_chg_o,
    output logic                         newda_reject_o,
    output logic [NumDevs-1:0]           overrun_o,
    input  logic [NumDevs-1:0]           overrun_clr_i,
    output logic [RstActWidth-1:0]       rst_action_o,
    output logic                         rst_action_we_o
);

    logic [NumDevs-1:0]   pend_q, pend_d;
    logic [NumDevs-1:0]   valid_q, valid_d;
    logic [AddrWidth-1:0] addr_q [NumDevs];
    logic [AddrWidth-1:0] addr_d [NumDevs];
    logic [NumDevs-1:0]   overrun_q, overrun_d;
    logic [NumDevs-1:0]   chg_q;
    logic                 reject_q, reject_d;
    logic [RstActWidth-1:0] rst_act_q;
    logic                 rst_act_we_q;

    logic [NumDevs-1:0] grant;
    logic [NumDevs-1:0] dasa_hit;
    logic [NumDevs-1:0] newda_ok;

    rr_arbiter #(
        .N (NumDevs)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (pend_q & ~sw_busy_i),
        .advance_i (1'b1),
        .grant_o   (grant)
    );

    // SETNEWDA is only honoured for a device that already owns (or is about to own) an address.
    always_comb begin
        dasa_hit = '0;
        newda_ok = '0;
        for (int unsigned d = 0; d < NumDevs; d++) begin
            dasa_hit[d] = set_dasa_valid_i && (set_dasa_dev_i == DevIdxW'(d));
            newda_ok[d] = set_newda_i && (newda_dev_i == DevIdxW'(d)) &&
                          (cur_valid_i[d] || (pend_q[d] && valid_q[d]));
        end
        reject_d = set_newda_i && (newda_ok == '0);
    end

    always_comb begin
        logic load;
        pend_d    = pend_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        overrun_d = overrun_q & ~overrun_clr_i;
        load      = 1'b0;
        for (int unsigned d = 0; d < NumDevs; d++) begin
            if (grant[d]) pend_d[d] = 1'b0;
            load = rstdaa_i || dasa_hit[d] || newda_ok[d];
            if (rstdaa_i) begin
                addr_d[d]  = '0;
                valid_d[d] = 1'b0;
            end else if (dasa_hit[d]) begin
                addr_d[d]  = set_dasa_addr_i;
                valid_d[d] = 1'b1;
            end else if (newda_ok[d]) begin
                addr_d[d]  = newda_i;
                valid_d[d] = 1'b1;
            end
            if (load) begin
                pend_d[d] = 1'b1;
                if (pend_q[d] && !grant[d]) overrun_d[d] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= '0;
            valid_q      <= '0;
            overrun_q    <= '0;
            chg_q        <= '0;
            reject_q     <= 1'b0;
            rst_act_q    <= '0;
            rst_act_we_q <= 1'b0;
            for (int unsigned d = 0; d < NumDevs; d++) addr_q[d] <= '0;
        end else begin
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
            chg_q     <= grant;
            reject_q  <= reject_d;
            if (rst_action_valid_i) begin
                rst_act_q    <= rst_action_i;
                rst_act_we_q <= 1'b1;
            end else if (rst_action_clr_i) begin
                rst_act_q    <= '0;
                rst_act_we_q <= 1'b1;
            end else begin
                rst_act_we_q <= 1'b0;
            end
        end
    end

    always_comb begin
        addr_we_o         = grant;
        addr_next_o       = '0;
        addr_valid_next_o = '0;
        for (int unsigned d = 0; d < NumDevs; d++) begin
            if (grant[d]) begin
                addr_next_o[d*AddrWidth +: AddrWidth] = addr_q[d];
                addr_valid_next_o[d]                  = valid_q[d];
            end
        end
    end

    assign pending_o       = pend_q;
    assign dyn_addr_chg_o  = chg_q;
    assign newda_reject_o  = reject_q;
    assign overrun_o       = overrun_q;
    assign rst_action_o    = rst_act_q;
    assign rst_action_we_o = rst_act_we_q;

endmodule

// File: tb/tb_dyn_addr_update_ctrl.sv
// Directed bench for dyn_addr_update_ctrl with NumDevs=2.
module tb_dyn_addr_update_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        set_dasa_valid_i;
    logic [6:0]  set_dasa_addr_i;
    logic [0:0]  set_dasa_dev_i;
    logic        rstdaa_i;
    logic        set_newda_i;
    logic [6:0]  newda_i;
    logic [0:0]  newda_dev_i;
    logic        rst_action_valid_i;
    logic [7:0]  rst_action_i;
    logic        rst_action_clr_i;
    logic [1:0]  sw_busy_i;
    logic [1:0]  cur_valid_i;
    logic [1:0]  addr_we_o;
    logic [13:0] addr_next_o;
    logic [1:0]  addr_valid_next_o;
    logic [1:0]  pending_o;
    logic [1:0]  dyn_addr_chg_o;
    logic        newda_reject_o;
    logic [1:0]  overrun_o;
    logic [1:0]  overrun_clr_i;
    logic [7:0]  rst_action_o;
    logic        rst_action_we_o;

    int tests_run    = 0;
    int tests_failed = 0;

    dyn_addr_update_ctrl #(
        .NumDevs     (2),
        .AddrWidth   (7),
        .RstActWidth (8)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .set_dasa_valid_i   (set_dasa_valid_i),
        .set_dasa_addr_i    (set_dasa_addr_i),
        .set_dasa_dev_i     (set_dasa_dev_i),
        .rstdaa_i           (rstdaa_i),
        .set_newda_i        (set_newda_i),
        .newda_i            (newda_i),
        .newda_dev_i        (newda_dev_i),
        .rst_action_valid_i (rst_action_valid_i),
        .rst_action_i       (rst_action_i),
        .rst_action_clr_i   (rst_action_clr_i),
        .sw_busy_i          (sw_busy_i),
        .cur_valid_i        (cur_valid_i),
        .addr_we_o          (addr_we_o),
        .addr_next_o        (addr_next_o),
        .addr_valid_next_o  (addr_valid_next_o),
        .pending_o          (pending_o),
        .dyn_addr_chg_o     (dyn_addr_chg_o),
        .newda_reject_o     (newda_reject_o),
        .overrun_o          (overrun_o),
        .overrun_clr_i      (overrun_clr_i),
        .rst_action_o       (rst_action_o),
        .rst_action_we_o    (rst_action_we_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        set_dasa_valid_i   = 1'b0;
        set_dasa_addr_i    = '0;
        set_dasa_dev_i     = '0;
        rstdaa_i           = 1'b0;
        set_newda_i        = 1'b0;
        newda_i            = '0;
        newda_dev_i        = '0;
        rst_action_valid_i = 1'b0;
        rst_action_i       = '0;
        rst_action_clr_i   = 1'b0;
        sw_busy_i          = '0;
        cur_valid_i        = '0;
        overrun_clr_i      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        do_reset();
        check_eq("reset_pending", 32'(pending_o), 32'h0);
        check_eq("reset_overrun", 32'(overrun_o), 32'h0);
        check_eq("reset_rstact", 32'(rst_action_o), 32'h0);
        check_eq("reset_we", 32'(addr_we_o), 32'h0);
        check_eq("reset_next", 32'(addr_next_o), 32'h0);
        check_eq("reset_chg", 32'(dyn_addr_chg_o), 32'h0);

        // SETDASA dev0 0x2A: commit next cycle, change pulse the one after.
        set_dasa_valid_i = 1'b1; set_dasa_addr_i = 7'h2A; set_dasa_dev_i = 1'b0;
        tick();
        idle_inputs(); #1;
        check_eq("dasa_pending", 32'(pending_o), 32'h1);
        check_eq("dasa_we", 32'(addr_we_o), 32'h1);
        check_eq("dasa_next", 32'(addr_next_o), 32'h002A);
        check_eq("dasa_vnext", 32'(addr_valid_next_o), 32'h1);
        check_eq("dasa_chg_early", 32'(dyn_addr_chg_o), 32'h0);
        tick();
        check_eq("dasa_chg", 32'(dyn_addr_chg_o), 32'h1);
        check_eq("dasa_we_done", 32'(addr_we_o), 32'h0);
        check_eq("dasa_pend_done", 32'(pending_o), 32'h0);

        // Same-cycle SETDASA dev1 and SETNEWDA dev0.
        do_reset();
        cur_valid_i = 2'b01;
        set_dasa_valid_i = 1'b1; set_dasa_addr_i = 7'h31; set_dasa_dev_i = 1'b1;
        set_newda_i = 1'b1; newda_i = 7'h40; newda_dev_i = 1'b0;
        tick();
        idle_inputs(); #1;
        check_eq("dual_we0", 32'(addr_we_o), 32'h1);
        check_eq("dual_next0", 32'(addr_next_o), 32'h0040);
        check_eq("dual_noreject", 32'(newda_reject_o), 32'h0);
        tick();
        check_eq("dual_we1", 32'(addr_we_o), 32'h2);
        check_eq("dual_next1", 32'(addr_next_o), 32'h1880);
        check_eq("dual_chg0", 32'(dyn_addr_chg_o), 32'h1);
        tick();
        check_eq("dual_chg1", 32'(dyn_addr_chg_o), 32'h2);

        // RSTDAA overrides a coincident SETDASA.
        do_reset();
        rstdaa_i = 1'b1;
        set_dasa_valid_i = 1'b1; set_dasa_addr_i = 7'h10; set_dasa_dev_i = 1'b0;
        tick();
        idle_inputs(); #1;
        check_eq("rstdaa_pending", 32'(pending_o), 32'h3);
        check_eq("rstdaa_we0", 32'(addr_we_o), 32'h1);
        check_eq("rstdaa_next0", 32'(addr_next_o), 32'h0);
        check_eq("rstdaa_vnext0", 32'(addr_valid_next_o), 32'h0);
        tick();
        check_eq("rstdaa_we1", 32'(addr_we_o), 32'h2);
        check_eq("rstdaa_next1", 32'(addr_next_o), 32'h0);
        check_eq("rstdaa_vnext1", 32'(addr_valid_next_o), 32'h0);

        // SETNEWDA to a device without an address is rejected.
        do_reset();
        set_newda_i = 1'b1; newda_i = 7'h55; newda_dev_i = 1'b1;
        tick();
        idle_inputs(); #1;
        check_eq("reject_pulse", 32'(newda_reject_o), 32'h1);
        check_eq("reject_we", 32'(addr_we_o), 32'h0);
        check_eq("reject_pend", 32'(pending_o), 32'h0);
        tick();
        check_eq("reject_end", 32'(newda_reject_o), 32'h0);

        // Software busy defers the commit for three cycles.
        do_reset();
        set_dasa_valid_i = 1'b1; set_dasa_addr_i = 7'h22; set_dasa_dev_i = 1'b0;
        tick();
        idle_inputs(); sw_busy_i = 2'b01; #1;
        check_eq("busy_we_c1", 32'(addr_we_o), 32'h0);
        tick();
        check_eq("busy_we_c2", 32'(addr_we_o), 32'h0);
        tick();
        check_eq("busy_we_c3", 32'(addr_we_o), 32'h0);
        check_eq("busy_pend", 32'(pending_o), 32'h1);
        tick();
        sw_busy_i = 2'b00; #1;
        check_eq("busy_we_c4", 32'(addr_we_o), 32'h1);
        check_eq("busy_next", 32'(addr_next_o), 32'h0022);

        // Overwrite of a deferred slot flags overrun; latest value wins.
        do_reset();
        sw_busy_i = 2'b01;
        set_dasa_valid_i = 1'b1; set_dasa_addr_i = 7'h11; set_dasa_dev_i = 1'b0;
        tick();
        set_dasa_addr_i = 7'h12; #1;
        check_eq("ovr_not_yet", 32'(overrun_o), 32'h0);
        tick();
        idle_inputs(); #1;
        check_eq("ovr_set", 32'(overrun_o), 32'h1);
        check_eq("ovr_we", 32'(addr_we_o), 32'h1);
        check_eq("ovr_next", 32'(addr_next_o), 32'h0012);
        tick();
        overrun_clr_i = 2'b01; #1;
        check_eq("ovr_hold", 32'(overrun_o), 32'h1);
        tick();
        overrun_clr_i = 2'b00; #1;
        check_eq("ovr_clr", 32'(overrun_o), 32'h0);

        // Mid-operation reset discards pending slots.
        set_dasa_valid_i = 1'b1; set_dasa_addr_i = 7'h33; set_dasa_dev_i = 1'b1;
        sw_busy_i = 2'b10;
        tick();
        idle_inputs(); sw_busy_i = 2'b10; rst_i = 1'b1;
        tick();
        rst_i = 1'b0; sw_busy_i = 2'b00; #1;
        check_eq("midrst_pend", 32'(pending_o), 32'h0);
        check_eq("midrst_we", 32'(addr_we_o), 32'h0);

        // RSTACT latch, clear, and valid-beats-clear.
        rst_action_valid_i = 1'b1; rst_action_i = 8'h02;
        tick();
        idle_inputs(); #1;
        check_eq("ra_byte", 32'(rst_action_o), 32'h02);
        check_eq("ra_we", 32'(rst_action_we_o), 32'h1);
        tick();
        check_eq("ra_we_end", 32'(rst_action_we_o), 32'h0);
        rst_action_clr_i = 1'b1;
        tick();
        idle_inputs(); #1;
        check_eq("ra_clr_byte", 32'(rst_action_o), 32'h00);
        check_eq("ra_clr_we", 32'(rst_action_we_o), 32'h1);
        rst_action_valid_i = 1'b1; rst_action_i = 8'h05; rst_action_clr_i = 1'b1;
        tick();
        idle_inputs(); #1;
        check_eq("ra_both", 32'(rst_action_o), 32'h05);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
